// File: rtl/phase_seq_gen.sv
// Programmable multi-phase clock-enable sequencer: walks a writable pattern table
// up to a programmable last index, with free-run, single-step and halt-at-wrap control.
module phase_seq_gen #(
    parameter int NUM_OUT    = 5,
    parameter int NUM_STATES = 8,
    parameter int STATE_W    = 3
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               ena,
    input  logic               step_mode,
    input  logic               step,
    input  logic               halt_req,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_addr,
    input  logic [NUM_OUT-1:0] cfg_data,
    input  logic [STATE_W-1:0] cfg_len,
    output logic [NUM_OUT-1:0] phase_out,
    output logic [STATE_W-1:0] state_out,
    output logic               cycle_done,
    output logic               halted
);

    typedef enum logic {
        RUN,
        HALTED
    } fsm_t;

    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] len_q, len_d;
    logic [NUM_OUT-1:0] phase_q, phase_d;
    logic               done_q, done_d;
    logic               halted_q, halted_d;
    logic [NUM_OUT-1:0] table_q [NUM_STATES];
    logic [NUM_OUT-1:0] table_d [NUM_STATES];

    logic               adv;
    logic               wrap;
    logic               addr_ok;
    logic [STATE_W-1:0] len_clamped;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        len_d    = len_q;
        phase_d  = phase_q;
        done_d   = done_q;
        halted_d = halted_q;
        table_d  = table_q;

        // Widened compares keep these meaningful when the table fills the index space.
        len_clamped = ({1'b0, cfg_len} > {1'b0, LAST}) ? LAST : cfg_len;
        addr_ok     = ({1'b0, cfg_addr} < (STATE_W + 1)'(NUM_STATES));

        adv  = ena && (fsm_q == RUN) && (!step_mode || step);
        wrap = (state_q == len_q);

        if (adv) begin
            phase_d  = table_q[state_q];
            done_d   = wrap;
            halted_d = 1'b0;
            if (wrap) begin
                state_d = '0;
                len_d   = len_clamped;
                if (halt_req) fsm_d = HALTED;
            end else begin
                state_d = state_q + STATE_W'(1);
            end
        end else if (ena) begin
            phase_d = '0;
            done_d  = 1'b0;
            if (fsm_q == HALTED) begin
                state_d = '0;
                len_d   = len_clamped;
                if (!halt_req) fsm_d = RUN;
            end
            // halted rises the cycle after the final emission, once the strobes are quiet.
            halted_d = (fsm_d == HALTED);
        end

        // The read above uses table_q, so a same-entry write shows up on the next visit.
        if (cfg_we && addr_ok) table_d[cfg_addr] = cfg_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            fsm_q    <= RUN;
            state_q  <= '0;
            len_q    <= LAST;
            phase_q  <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            // NOTE: the table is deliberately reset; its default one-hot contents are functional.
            for (int i = 0; i < NUM_STATES; i++) begin
                table_q[i] <= NUM_OUT'(1) << (i % NUM_OUT);
            end
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            len_q    <= len_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
            halted_q <= halted_d;
            table_q  <= table_d;
        end
    end

    assign phase_out  = phase_q;
    assign state_out  = state_q;
    assign cycle_done = done_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_phase_seq_gen.sv
// Directed and randomized checks of phase_seq_gen against a table-walking reference model.
module tb_phase_seq_gen;

    localparam int NO = 5;
    localparam int NS = 8;
    localparam int SW = 3;

    logic          clk_in = 1'b0;
    logic          rst = 1'b0, rst_s = 1'b0;
    logic          ena = 1'b0, step_mode = 1'b0, step = 1'b0, halt_req = 1'b0, cfg_we = 1'b0;
    logic [SW-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_len = 3'd7;
    logic [NO-1:0] cfg_data = '0;

    logic [NO-1:0] phase_out, phase_s;
    logic [SW-1:0] state_out, state_s;
    logic          cycle_done, halted, done_s, halted_s;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: the table contents, the active last index, the next index to emit.
    int m_tab [NS];
    int m_len, m_state, m_phase;
    bit m_done, m_hstate, m_halted;

    always #5 clk_in = ~clk_in;

    phase_seq_gen #(.NUM_OUT(NO), .NUM_STATES(NS), .STATE_W(SW)) dut (
        .clk_in(clk_in), .rst(rst), .ena(ena), .step_mode(step_mode), .step(step),
        .halt_req(halt_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len(cfg_len), .phase_out(phase_out), .state_out(state_out),
        .cycle_done(cycle_done), .halted(halted)
    );

    phase_seq_gen #(.NUM_OUT(NO), .NUM_STATES(6), .STATE_W(SW)) u_small (
        .clk_in(clk_in), .rst(rst_s), .ena(ena), .step_mode(step_mode), .step(step),
        .halt_req(halt_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len(cfg_len), .phase_out(phase_s), .state_out(state_s),
        .cycle_done(done_s), .halted(halted_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_tab[i] = 1 << (i % NO);
        m_len    = NS - 1;
        m_state  = 0;
        m_phase  = 0;
        m_done   = 1'b0;
        m_hstate = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock of the sequencing rules, using the inputs as they stand at the edge.
    task automatic model_step();
        bit adv;
        int clamp;
        adv   = ena && !m_hstate && (!step_mode || step);
        clamp = (int'(cfg_len) > NS - 1) ? NS - 1 : int'(cfg_len);
        if (adv) begin
            m_phase  = m_tab[m_state];
            m_done   = (m_state == m_len);
            m_halted = 1'b0;
            if (m_state == m_len) begin
                m_state  = 0;
                m_len    = clamp;
                m_hstate = halt_req;
            end else begin
                m_state++;
            end
        end else if (ena) begin
            m_phase = 0;
            m_done  = 1'b0;
            if (m_hstate) begin
                m_len    = clamp;
                m_hstate = halt_req;
            end
            m_halted = m_hstate;
        end
        if (cfg_we && int'(cfg_addr) < NS) m_tab[cfg_addr] = int'(cfg_data);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
        check("phase_out", phase_out, m_phase);
        check("state_out", state_out, m_state);
        check("cycle_done", cycle_done, m_done);
        check("halted", halted, m_halted);
    endtask

    task automatic wait_state(input int target);
        int n;
        n = 0;
        while (int'(state_out) != target && n < 20) begin
            cycle();
            n++;
        end
        check("wait_state", state_out, target);
    endtask

    initial begin
        int def   [8] = '{1, 2, 4, 8, 16, 1, 2, 4};
        int leg   [8] = '{'h01, 'h02, 'h04, 'h00, 'h0D, 'h00, 'h00, 'h10};
        int shrink[11] = '{'h00, 'h00, 'h10, 'h01, 'h02, 'h04, 'h00, 'h01, 'h02, 'h04, 'h00};
        int def6  [6] = '{1, 2, 4, 8, 16, 1};
        int st0;
        int nz;
        logic [NO-1:0] ph_hold;
        logic [SW-1:0] st_hold;

        model_reset();
        #12;
        check("rst_phase", phase_out, 0);
        check("rst_state", state_out, 0);
        check("rst_done", cycle_done, 0);
        check("rst_halted", halted, 0);
        rst = 1'b1;

        // Default one-hot table, free-running.
        ena = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            check("default_seq", phase_out, def[k % 8]);
            check("default_done", cycle_done, (k % 8) == 7);
        end

        // Legacy GCore pattern set, loaded while frozen.
        ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = SW'(i); cfg_data = NO'(leg[i]);
            cycle();
        end
        cfg_we = 1'b0; cfg_len = 3'd7; ena = 1'b1;
        wait_state(0);
        for (int k = 0; k < 16; k++) begin
            cycle();
            check("legacy_seq", phase_out, leg[k % 8]);
            check("legacy_pc", phase_out[0], (k % 8) == 0 || (k % 8) == 4);
        end

        // Shorten the sequence mid-pass; takes effect only after the wrap.
        wait_state(5);
        cfg_len = 3'd3;
        for (int k = 0; k < 11; k++) begin
            cycle();
            check("shrink_seq", phase_out, shrink[k]);
            check("shrink_done", cycle_done, k == 2 || k == 6 || k == 10);
        end

        // Restore full length, then halt requested at state 2.
        cfg_len = 3'd7;
        cycle();
        wait_state(0);
        wait_state(2);
        halt_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("halt_drain", phase_out, leg[2 + k]);
        end
        check("halt_last_done", cycle_done, 1);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("halted_flag", halted, 1);
            check("halted_phase", phase_out, 0);
            check("halted_state", state_out, 0);
        end
        halt_req = 1'b0;
        cycle();
        check("resume_quiet", phase_out, 0);
        check("resume_flag", halted, 0);
        cycle();
        check("resume_first", phase_out, leg[0]);

        // Single-step mode with nonzero entries everywhere.
        step_mode = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 3'd3; cfg_data = 5'h03; cycle();
        cfg_addr = 3'd5; cfg_data = 5'h0A; cycle();
        cfg_addr = 3'd6; cfg_data = 5'h14; cycle();
        cfg_we = 1'b0;
        for (int p = 0; p < 10; p++) begin
            st0 = int'(state_out);
            nz  = 0;
            step = 1'b1;
            cycle();
            step = 1'b0;
            if (phase_out != 0) nz++;
            check("step_state", state_out, (st0 + 1) % 8);
            for (int g = 0; g < 2; g++) begin
                cycle();
                if (phase_out != 0) nz++;
            end
            check("step_one_strobe", nz, 1);
        end
        for (int p = 0; p < 4; p++) begin
            step = 1'b1;
            cycle();
            step = 1'b0;
            ph_hold = phase_out;
            st_hold = state_out;
            ena = 1'b0;
            for (int g = 0; g < 2; g++) begin
                cycle();
                check("frozen_phase", phase_out, ph_hold);
                check("frozen_state", state_out, st_hold);
            end
            ena = 1'b1;
        end
        st0 = int'(state_out);
        step = 1'b1;
        for (int g = 0; g < 3; g++) cycle();
        step = 1'b0;
        check("step_held_3", state_out, (st0 + 3) % 8);

        // Same-entry write while that entry is being emitted.
        step_mode = 1'b0;
        wait_state(2);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 5'h1B;
        cycle();
        cfg_we = 1'b0;
        check("same_cycle_old", phase_out, 'h04);
        wait_state(2);
        cycle();
        check("same_cycle_new", phase_out, 'h1B);

        // Asynchronous reset mid-run restores the default table.
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check("async_phase", phase_out, 0);
        check("async_state", state_out, 0);
        check("async_done", cycle_done, 0);
        model_reset();
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("post_rst_seq", phase_out, def[k]);
        end

        // Six-entry table: out-of-range writes ignored, cfg_len clamped to 5.
        rst_s = 1'b1;
        ena = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = 3'd6; cfg_data = 5'h1F; cycle();
        cfg_addr = 3'd7; cfg_data = 5'h1F; cycle();
        cfg_we = 1'b0; cfg_len = 3'd7; ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check("small_seq", phase_s, def6[k % 6]);
            check("small_done", done_s, (k % 6) == 5);
            check("small_state", state_s, (k + 1) % 6);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            ena       = ($urandom_range(0, 9) != 0);
            step_mode = ($urandom_range(0, 3) == 0);
            step      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = SW'($urandom);
            cfg_data  = NO'($urandom);
            if ($urandom_range(0, 15) == 0) cfg_len = SW'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_seq_gen.md
Name: phase_seq_gen

Overview:
- Programmable multi-phase clock-enable sequencer; parametrised successor to the fixed 8-state CPU phase generator.
- Generates NUM_OUT phase strobes (pc, opram, mem, acc, led_out, ...) from a writable pattern table of up to NUM_STATES entries.
- Adds a programmable sequence length, single-step mode, and a halt-at-end-of-sequence request.
- Sits between the board clock and the GCore datapath; the debug/control interface drives its cfg and step ports.

Parameters:
- NUM_OUT, 5, number of phase outputs (pattern width).
- NUM_STATES, 8, pattern table depth (maximum sequence length).
- STATE_W, 3, state index width; must satisfy 2^STATE_W >= NUM_STATES.

Ports:
- clk_in  in  1  system clock; all logic on its posedge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; low freezes all state and outputs.
- step_mode  in  1  1 = advance only on step; 0 = free-run.
- step  in  1  one-cycle advance pulse, used when step_mode=1.
- halt_req  in  1  request to stop at the end of the current sequence.
- cfg_we  in  1  pattern table write strobe.
- cfg_addr  in  STATE_W  pattern table entry index.
- cfg_data  in  NUM_OUT  pattern value to write.
- cfg_len  in  STATE_W  index of the last state in the sequence.
- phase_out  out  NUM_OUT  registered phase strobes.
- state_out  out  STATE_W  index of the next state to be emitted.
- cycle_done  out  1  one-cycle pulse when the last state is emitted.
- halted  out  1  high while in the HALTED state.

Behaviour:
- Reset (async, rst=0):
  - phase_out=0, state_out=0, cycle_done=0, halted=0, FSM=RUN.
  - len_active=NUM_STATES-1.
  - table[i] = one-hot bit (i mod NUM_OUT).
- Advance condition (adv): ena=1 AND FSM=RUN AND (step_mode=0 OR step=1).
- On adv with current index s:
  - phase_out <= table[s].
  - cycle_done <= (s==len_active).
  - If s==len_active: state <= 0. Otherwise state <= s+1.
- No adv:
  - If ena=0: phase_out, state and cycle_done hold their values.
  - If ena=1 (not advancing, step-mode wait or HALTED): phase_out <= 0, cycle_done <= 0, state holds.
- Latency: one cycle from adv to the phase_out update.
- Sequence length:
  - len_active <= min(cfg_len, NUM_STATES-1).
  - Loaded only on the wrap advance (s==len_active) and while HALTED.
  - Therefore the state index can never exceed len_active.
- FSM:
  - RUN -> HALTED: on the wrap advance when halt_req=1. That cycle still emits table[len_active] with cycle_done=1.
  - In HALTED: halted=1, phase_out=0, state=0.
  - HALTED -> RUN: the cycle after halt_req=0 with ena=1. The first adv in RUN emits table[0].
  - halt_req rising mid-sequence: the remaining states are still emitted before halting.
- Pattern table:
  - Written on cfg_we=1 when cfg_addr < NUM_STATES; writes with cfg_addr >= NUM_STATES are ignored.
  - Writes are accepted regardless of ena and FSM state.
  - Write and read of the same entry in the same cycle: the old value is emitted; the new value is used on the next visit.
- Step mode:
  - step held high for k cycles produces k advances.
  - Switching step_mode takes effect in the same cycle.
- Reset mid-operation: outputs clear immediately (asynchronous). The table returns to its defaults.
- Legacy compatibility: loading the GCore 8-entry pattern set with cfg_len=7 reproduces the original pc/opram/mem/acc/led_out phasing.

Test Plan:
- Reset, ena=1, step_mode=0, defaults (NUM_OUT=5) -> phase_out sequence 00001, 00010, 00100, 01000, 10000, 00001, 00010, 00100, then repeats.
  - cycle_done pulses with the 8th output.
- Load legacy patterns {01,02,04,00,0D,00,00,10}, cfg_len=7 -> phase_out repeats that sequence with period 8.
  - pc bit high in states 0 and 4.
- Set cfg_len=3 mid-sequence at state 5 -> states 5..7 are still emitted; after the wrap the period becomes 4 (entries 0..3).
- Assert halt_req at state 2 -> states 2..7 are emitted, cycle_done=1, then halted=1 and phase_out=0.
  - Deassert halt_req -> table[0] appears 2 cycles later.
- step_mode=1, step pulses 3 cycles apart -> exactly one nonzero phase_out per step, state_out increments by 1 per pulse.
  - ena=0 between pulses holds phase_out and state_out.
- Write cfg_addr=2 on the same cycle state 2 is emitted -> the old value is output; the new value appears on the next pass.
  - cfg_we with cfg_addr beyond the table depth (when NUM_STATES < 2^STATE_W) -> no table change.
